pp_seq_gen: RTL and testbench
=============================

// Module: pp_seq_gen
// PURPOSE
//  Stimulus transmitter for the PP_1-family sequence detectors; the driving end of the (x,y) symbol interface.
//  On a start request it emits the traversal sequence {x,y} = 10, 01, 00, one symbol per clock.
//  That sequence walks the detector SA->SB->SC->SD. The detector output q is then sampled once.
//  The pass repeats a programmable number of times and the block counts passes in which q was high.
//  It sits beside the detector in self-test and bring-up builds, in place of a hand-written bench stimulus.
// PARAMETERS
//  REP_W    4      width of rep_cnt (max passes = 2**REP_W-1)
//  HIT_W    4      width of hit_cnt; saturates at 2**HIT_W-1
//  SYM0     2'b10  first symbol {x,y}
//  SYM1     2'b01  second symbol {x,y}
//  SYM2     2'b00  third symbol {x,y}
//  IDLE_SYM 2'b00  {x,y} driven whenever not in a SEND state
// PORTS
//  Clk      in   1      clock, all state updates on posedge
//  Rst      in   1      synchronous reset, active-low (Rst==0 at posedge resets)
//  start    in   1      request; accepted only when ready==1
//  rep_cnt  in   REP_W  number of passes, latched at start acceptance
//  q        in   1      detector output, sampled only in CHECK
//  x        out  1      symbol bit x to detector (registered)
//  y        out  1      symbol bit y to detector (registered)
//  ready    out  1      1 in IDLE only
//  busy     out  1      1 in SEND0/SEND1/SEND2/CHECK
//  done     out  1      one-cycle pulse at end of run
//  hit_cnt  out  HIT_W  passes with q==1 in CHECK; cleared at start acceptance
// BEHAVIOUR
//  Reset values: state=IDLE, {x,y}=IDLE_SYM, ready=1, busy=0, done=0, hit_cnt=0, remaining-pass counter=0.
//  Reset mid-run aborts immediately to these values. No done pulse is produced for an aborted run.
//  States: IDLE, SEND0, SEND1, SEND2, CHECK, DONE. All outputs are registered and decoded from the current state.
//  IDLE: on start==1, latch rep_cnt into the remaining counter and clear hit_cnt.
//    If rep_cnt!=0, go to SEND0. If rep_cnt==0, go to DONE with no symbols emitted.
//  SEND0 drives {x,y}=SYM0. SEND1 drives {x,y}=SYM1. SEND2 drives {x,y}=SYM2.
//    Each SEND state lasts exactly one cycle: SEND0->SEND1->SEND2->CHECK.
//  CHECK: drives IDLE_SYM and samples q at the closing edge.
//    If q==1, hit_cnt increments, saturating at 2**HIT_W-1.
//    The remaining counter decrements. If the new value is !=0, go to SEND0; otherwise go to DONE.
//  DONE: done=1 for exactly one cycle, then IDLE. hit_cnt holds its value until the next accepted start.
//  Latency: start sampled at edge k gives SYM0 visible in cycle k+1.
//    CHECK of pass p falls in cycle k+4p. done is high in cycle k+4n+1 (n = rep_cnt).
//  Back-to-back passes have no idle gap: SYM0 of pass p+1 immediately follows CHECK of pass p.
//  start while ready==0 (including in DONE) is ignored and not queued. rep_cnt changes after acceptance have no effect.
//  q is ignored outside CHECK. x and y never change except at posedge Clk.
// TESTING
//  1. Hold Rst=0 for 2 cycles, then release -> x=0, y=0, ready=1, busy=0, done=0, hit_cnt=0.
//  2. start with rep_cnt=1; drive q=1 in CHECK -> {x,y}=10,01,00 in cycles k+1..k+3; hit_cnt=1; done pulse in cycle k+5.
//  3. start with rep_cnt=3; hold q=0 -> symbol pattern 10,01,00,00 repeated 3 times; hit_cnt=0; done in cycle k+13.
//  4. start with rep_cnt=0 -> no SEND states; done in cycle k+1; hit_cnt=0; x and y stay 0.
//  5. Pulse start during SEND1, then assert Rst=0 during pass 2 of a rep_cnt=3 run.
//     -> the start pulse is ignored; after reset the next cycle shows IDLE values and no done pulse.
//  6. HIT_W=2, rep_cnt=5, q tied to 1 -> hit_cnt reads 1,2,3,3,3 after successive CHECKs; final value 3.

Source files
------------

// File: rtl/pp_seq_gen.sv
// pp_seq_gen: emits the {x,y} traversal 10,01,00 per pass, samples the detector q and counts hits
module pp_seq_gen #(
  parameter int         REP_W    = 4,
  parameter int         HIT_W    = 4,
  parameter logic [1:0] SYM0     = 2'b10,
  parameter logic [1:0] SYM1     = 2'b01,
  parameter logic [1:0] SYM2     = 2'b00,
  parameter logic [1:0] IDLE_SYM = 2'b00
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic             q,
  output logic             x,
  output logic             y,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [HIT_W-1:0] hit_cnt
);
  typedef enum logic [2:0] {IDLE, SEND0, SEND1, SEND2, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [REP_W-1:0] rem_q, rem_d;
  logic [HIT_W-1:0] hit_q, hit_d;
  logic [1:0] sym_q, sym_d;
  logic ready_q, busy_q, done_q;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    hit_d = hit_q;
    case (state_q)
      IDLE: if (start) begin
        rem_d = rep_cnt;
        hit_d = '0;
        state_d = (rep_cnt != '0) ? SEND0 : DONE;
      end
      SEND0: state_d = SEND1;
      SEND1: state_d = SEND2;
      SEND2: state_d = CHECK;
      CHECK: begin
        rem_d = rem_q - REP_W'(1);
        hit_d = (q && hit_q != '1) ? hit_q + HIT_W'(1) : hit_q;
        state_d = (rem_d != '0) ? SEND0 : DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they decode
  assign sym_d = (state_d == SEND0) ? SYM0 :
                 (state_d == SEND1) ? SYM1 :
                 (state_d == SEND2) ? SYM2 : IDLE_SYM;
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      hit_q <= '0;
      sym_q <= IDLE_SYM;
      ready_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      hit_q <= hit_d;
      sym_q <= sym_d;
      ready_q <= state_d == IDLE;
      busy_q <= state_d inside {SEND0, SEND1, SEND2, CHECK};
      done_q <= state_d == DONE;
    end
  end
  assign {x, y} = sym_q;
  assign ready = ready_q;
  assign busy = busy_q;
  assign done = done_q;
  assign hit_cnt = hit_q;
endmodule

// File: tb/tb_pp_seq_gen.sv
// tb_pp_seq_gen: scoreboard bench for pp_seq_gen with default and 2-bit hit counter instances
module tb_pp_seq_gen;
  logic Clk = 0, Rst = 0, start = 0, q = 0;
  logic [3:0] rep_cnt = 0;
  logic xa, ya, ra, ba, da, xb, yb, rb, bb, db;
  logic [3:0] hita;
  logic [1:0] hitb;
  int vec = 0, err = 0, ha = 0, hb = 0;
  typedef struct packed {logic qd; logic [15:0] v;} exp_t;
  exp_t sb[$];
  exp_t e;

  pp_seq_gen dut_a (.Clk(Clk), .Rst(Rst), .start(start), .rep_cnt(rep_cnt), .q(q),
    .x(xa), .y(ya), .ready(ra), .busy(ba), .done(da), .hit_cnt(hita));
  pp_seq_gen #(.HIT_W(2)) dut_b (.Clk(Clk), .Rst(Rst), .start(start), .rep_cnt(rep_cnt), .q(q),
    .x(xb), .y(yb), .ready(rb), .busy(bb), .done(db), .hit_cnt(hitb));

  always #5 Clk = ~Clk;

  function automatic logic [15:0] obs();
    return {xa, ya, ra, ba, da, hita, xb, yb, rb, bb, db, hitb};
  endfunction

  function automatic logic [15:0] mk(logic [1:0] xy, logic r, logic b, logic d, int a, int h);
    return {xy, r, b, d, 4'(a), xy, r, b, d, 2'(h)};
  endfunction

  task automatic push_run(int n, logic qv);
    ha = 0;
    hb = 0;
    for (int p = 0; p < n; p++) begin
      sb.push_back({~qv, mk(2'b10, 0, 1, 0, ha, hb)});
      sb.push_back({~qv, mk(2'b01, 0, 1, 0, ha, hb)});
      sb.push_back({~qv, mk(2'b00, 0, 1, 0, ha, hb)});
      sb.push_back({qv, mk(2'b00, 0, 1, 0, ha, hb)});
      if (qv) begin
        ha = (ha < 15) ? ha + 1 : 15;
        hb = (hb < 3) ? hb + 1 : 3;
      end
    end
    sb.push_back({~qv, mk(2'b00, 0, 0, 1, ha, hb)});
    sb.push_back({1'b0, mk(2'b00, 1, 0, 0, ha, hb)});
  endtask

  task automatic launch(int n);
    @(negedge Clk);
    start = 1;
    rep_cnt = 4'(n);
    @(posedge Clk);
    #1 start = 0;
    rep_cnt = 4'($urandom_range(1, 15));
  endtask

  task automatic test_reset();
    Rst = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1;
    @(negedge Clk);
    vec++;
    if (obs() !== mk(2'b00, 1, 0, 0, 0, 0)) begin
      err++;
      $display("FAIL reset got %b exp %b", obs(), mk(2'b00, 1, 0, 0, 0, 0));
    end
  endtask

  task automatic test_single();
    push_run(1, 1);
    launch(1);
    for (int c = 1; sb.size() > 0; c++) begin
      @(negedge Clk);
      e = sb.pop_front();
      vec++;
      if (obs() !== e.v) begin
        err++;
        $display("FAIL single cyc%0d got %b exp %b", c, obs(), e.v);
      end
      q = e.qd;
    end
  endtask

  task automatic test_multi();
    push_run(3, 0);
    launch(3);
    for (int c = 1; sb.size() > 0; c++) begin
      @(negedge Clk);
      e = sb.pop_front();
      vec++;
      if (obs() !== e.v) begin
        err++;
        $display("FAIL multi cyc%0d got %b exp %b", c, obs(), e.v);
      end
      q = e.qd;
    end
  endtask

  task automatic test_zero();
    push_run(0, 0);
    launch(0);
    for (int c = 1; sb.size() > 0; c++) begin
      @(negedge Clk);
      e = sb.pop_front();
      vec++;
      if (obs() !== e.v) begin
        err++;
        $display("FAIL zero cyc%0d got %b exp %b", c, obs(), e.v);
      end
      q = e.qd;
      start = (c == 1);
      rep_cnt = 4'd2;
    end
    start = 0;
  endtask

  task automatic test_abort();
    push_run(3, 1);
    launch(3);
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk);
      e = sb.pop_front();
      vec++;
      if (obs() !== e.v) begin
        err++;
        $display("FAIL abort cyc%0d got %b exp %b", c, obs(), e.v);
      end
      q = e.qd;
      start = (c == 2);
    end
    Rst = 0;
    sb.delete();
    for (int c = 0; c < 5; c++) sb.push_back({1'b0, mk(2'b00, 1, 0, 0, 0, 0)});
    for (int c = 7; sb.size() > 0; c++) begin
      @(negedge Clk);
      e = sb.pop_front();
      vec++;
      if (obs() !== e.v) begin
        err++;
        $display("FAIL abort_idle cyc%0d got %b exp %b", c, obs(), e.v);
      end
      Rst = 1;
      q = 1;
    end
    q = 0;
  endtask

  task automatic test_saturate();
    push_run(5, 1);
    launch(5);
    for (int c = 1; sb.size() > 0; c++) begin
      @(negedge Clk);
      e = sb.pop_front();
      vec++;
      if (obs() !== e.v) begin
        err++;
        $display("FAIL saturate cyc%0d got %b exp %b", c, obs(), e.v);
      end
      q = e.qd;
    end
    vec++;
    if (hitb !== 2'd3 || hita !== 4'd5) begin
      err++;
      $display("FAIL saturate_final got %0d/%0d exp 5/3", hita, hitb);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_abort();
    test_single();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
